// File: rtl/biriscv_mul_issue_ctrl.sv
// ---------------------------------------------------------------------------
// biriscv_mul_issue_ctrl
//   Single-outstanding issue controller for the iterative/pipelined multiplier.
//   Accepts one MUL from decode, strobes it into the multiplier, waits (with a
//   timeout) for the writeback, then holds a register-file write request until
//   the register file takes it. While an instruction is pending, decode is
//   stalled if it reads the pending destination.
//
// Ports
//   clk_i, rst_ni                  clock, async active-low reset
//   issue_*                        decode -> controller handshake and fields
//   hzd_ra_idx_i/hzd_rb_idx_i      sources of the instruction in decode
//   hzd_stall_o                    RAW hazard on the pending destination
//   mul_*_o                        dispatch strobe + latched instruction fields
//   mul_writeback_valid_i/value_i  multiplier result
//   rf_wr_*                        register-file write request / ack
//   busy_o                         not idle
//   err_o                          sticky timeout / spurious-writeback flag
// ---------------------------------------------------------------------------
module biriscv_mul_issue_ctrl #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        issue_valid_i,
    output logic        issue_ready_o,
    input  logic [31:0] issue_opcode_i,
    input  logic [31:0] issue_pc_i,
    input  logic [4:0]  issue_rd_idx_i,
    input  logic [31:0] issue_ra_operand_i,
    input  logic [31:0] issue_rb_operand_i,

    input  logic [4:0]  hzd_ra_idx_i,
    input  logic [4:0]  hzd_rb_idx_i,
    output logic        hzd_stall_o,

    output logic        mul_valid_o,
    output logic [31:0] mul_opcode_o,
    output logic [31:0] mul_pc_o,
    output logic [31:0] mul_ra_operand_o,
    output logic [31:0] mul_rb_operand_o,
    output logic [4:0]  mul_rd_idx_o,

    input  logic        mul_writeback_valid_i,
    input  logic [31:0] mul_writeback_value_i,

    output logic        rf_wr_en_o,
    output logic [4:0]  rf_wr_idx_o,
    output logic [31:0] rf_wr_data_o,
    input  logic        rf_wr_ready_i,

    output logic        busy_o,
    output logic        err_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DISPATCH = 2'd1,
        S_WAIT     = 2'd2,
        S_WRITE    = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [31:0]      opcode_q, opcode_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      ra_q, ra_d;
    logic [31:0]      rb_q, rb_d;
    logic [4:0]       rd_q, rd_d;
    logic [31:0]      wr_data_q, wr_data_d;

    logic accept;
    logic timeout;

    assign accept  = (state_q == S_IDLE) && issue_valid_i;
    // Writeback in the last WAIT cycle takes priority over the timeout.
    assign timeout = (state_q == S_WAIT) && !mul_writeback_valid_i && (cnt_q == CNT_LAST);

    // ---------------- state register ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            opcode_q  <= '0;
            pc_q      <= '0;
            ra_q      <= '0;
            rb_q      <= '0;
            rd_q      <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            opcode_q  <= opcode_d;
            pc_q      <= pc_d;
            ra_q      <= ra_d;
            rb_q      <= rb_d;
            rd_q      <= rd_d;
            wr_data_q <= wr_data_d;
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (issue_valid_i) state_d = S_DISPATCH;
            S_DISPATCH: state_d = S_WAIT;
            S_WAIT: begin
                if (mul_writeback_valid_i)
                    // A result for x0 is dropped here so no write to x0 is ever requested.
                    state_d = (rd_q != 5'd0) ? S_WRITE : S_IDLE;
                else if (timeout)
                    state_d = S_IDLE;
            end
            S_WRITE:    if (rf_wr_ready_i) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // ---------------- datapath next values ----------------
    always_comb begin
        opcode_d  = opcode_q;
        pc_d      = pc_q;
        ra_d      = ra_q;
        rb_d      = rb_q;
        rd_d      = rd_q;
        wr_data_d = wr_data_q;
        cnt_d     = cnt_q;
        err_d     = err_q;

        if (accept) begin
            opcode_d = issue_opcode_i;
            pc_d     = issue_pc_i;
            ra_d     = issue_ra_operand_i;
            rb_d     = issue_rb_operand_i;
            rd_d     = issue_rd_idx_i;
        end

        if (state_q == S_DISPATCH)
            cnt_d = '0;
        else if (state_q == S_WAIT)
            cnt_d = cnt_q + 1'b1;

        if ((state_q == S_WAIT) && mul_writeback_valid_i)
            wr_data_d = mul_writeback_value_i;

        // Result strobes outside WAIT have no owner: flag, never use the data.
        if (mul_writeback_valid_i && (state_q != S_WAIT))
            err_d = 1'b1;
        if (timeout)
            err_d = 1'b1;
    end

    // ---------------- outputs ----------------
    always_comb begin
        issue_ready_o = (state_q == S_IDLE) && rst_ni;
        mul_valid_o   = (state_q == S_DISPATCH);
        rf_wr_en_o    = (state_q == S_WRITE);
        rf_wr_idx_o   = (state_q == S_WRITE) ? rd_q : 5'd0;
        busy_o        = (state_q != S_IDLE);
        hzd_stall_o   = (state_q != S_IDLE) && (rd_q != 5'd0) &&
                        ((hzd_ra_idx_i == rd_q) || (hzd_rb_idx_i == rd_q));
    end

    assign mul_opcode_o     = opcode_q;
    assign mul_pc_o         = pc_q;
    assign mul_ra_operand_o = ra_q;
    assign mul_rb_operand_o = rb_q;
    assign mul_rd_idx_o     = rd_q;
    assign rf_wr_data_o     = wr_data_q;
    assign err_o            = err_q;

endmodule

// File: tb/tb_biriscv_mul_issue_ctrl.sv
// Testbench for biriscv_mul_issue_ctrl: the bench plays decode, multiplier and
// register file. Expected register writes (rd, ra*rb) are queued at issue time
// and a negedge monitor pops them on every accepted write.
module tb_biriscv_mul_issue_ctrl;

    localparam int TMO = 16;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        issue_valid_i;
    logic        issue_ready_o;
    logic [31:0] issue_opcode_i, issue_pc_i;
    logic [4:0]  issue_rd_idx_i;
    logic [31:0] issue_ra_operand_i, issue_rb_operand_i;
    logic [4:0]  hzd_ra_idx_i, hzd_rb_idx_i;
    logic        hzd_stall_o;
    logic        mul_valid_o;
    logic [31:0] mul_opcode_o, mul_pc_o, mul_ra_operand_o, mul_rb_operand_o;
    logic [4:0]  mul_rd_idx_o;
    logic        mul_writeback_valid_i;
    logic [31:0] mul_writeback_value_i;
    logic        rf_wr_en_o;
    logic [4:0]  rf_wr_idx_o;
    logic [31:0] rf_wr_data_o;
    logic        rf_wr_ready_i;
    logic        busy_o, err_o;

    biriscv_mul_issue_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_opcode_i(issue_opcode_i), .issue_pc_i(issue_pc_i),
        .issue_rd_idx_i(issue_rd_idx_i),
        .issue_ra_operand_i(issue_ra_operand_i), .issue_rb_operand_i(issue_rb_operand_i),
        .hzd_ra_idx_i(hzd_ra_idx_i), .hzd_rb_idx_i(hzd_rb_idx_i), .hzd_stall_o(hzd_stall_o),
        .mul_valid_o(mul_valid_o), .mul_opcode_o(mul_opcode_o), .mul_pc_o(mul_pc_o),
        .mul_ra_operand_o(mul_ra_operand_o), .mul_rb_operand_o(mul_rb_operand_o),
        .mul_rd_idx_o(mul_rd_idx_o),
        .mul_writeback_valid_i(mul_writeback_valid_i), .mul_writeback_value_i(mul_writeback_value_i),
        .rf_wr_en_o(rf_wr_en_o), .rf_wr_idx_o(rf_wr_idx_o), .rf_wr_data_o(rf_wr_data_o),
        .rf_wr_ready_i(rf_wr_ready_i),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_vec = 0;
    int  n_err = 0;
    bit  exp_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h want 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // ---------------- scoreboard monitor ----------------
    bit          hold;
    logic [4:0]  hold_idx;
    logic [31:0] hold_data;
    wr_t         got;

    always @(negedge clk_i) begin
        if (!rst_ni) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("bp_hold_en", 32'(rf_wr_en_o), 32'd1);
                chk("bp_hold_idx", 32'(rf_wr_idx_o), 32'(hold_idx));
                chk("bp_hold_data", rf_wr_data_o, hold_data);
            end
            if (rf_wr_en_o && rf_wr_idx_o == 5'd0) begin
                n_vec++; n_err++;
                $display("FAIL wr_x0: write to x0 requested (t=%0t)", $time);
            end
            if (rf_wr_en_o && rf_wr_ready_i) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL wr_unexpected: idx %0d data 0x%08h, none expected", rf_wr_idx_o, rf_wr_data_o);
                end else begin
                    got = exp_q.pop_front();
                    chk("sb_idx", 32'(rf_wr_idx_o), 32'(got.idx));
                    chk("sb_data", rf_wr_data_o, got.data);
                end
            end
            hold      = rf_wr_en_o && !rf_wr_ready_i;
            hold_idx  = rf_wr_idx_o;
            hold_data = rf_wr_data_o;
        end
    end

    // One instruction end to end. w = WAIT cycles before the writeback
    // (w >= TMO means no writeback at all), bp = cycles of write backpressure,
    // hz = force decode's ra index onto rd.
    task automatic do_txn(input logic [31:0] ra, input logic [31:0] rb, input logic [4:0] rd,
                          input int w, input int bp, input bit hz);
        logic [31:0] op, pc, prod, model;
        logic [4:0]  ha, hb;
        bit          tmo;
        wr_t         e;
        tmo   = (w >= TMO);
        op    = $urandom;
        pc    = $urandom;
        model = ra * rb;
        chk("ready_idle", 32'(issue_ready_o), 32'd1);
        issue_valid_i      = 1'b1;
        issue_opcode_i     = op;
        issue_pc_i         = pc;
        issue_rd_idx_i     = rd;
        issue_ra_operand_i = ra;
        issue_rb_operand_i = rb;
        if (!tmo && rd != 5'd0) begin
            e.idx = rd; e.data = model;
            exp_q.push_back(e);
        end
        tick();
        issue_valid_i      = 1'b0;
        issue_opcode_i     = $urandom;
        issue_pc_i         = $urandom;
        issue_rd_idx_i     = 5'($urandom);
        issue_ra_operand_i = $urandom;
        issue_rb_operand_i = $urandom;
        chk("dispatch_valid", 32'(mul_valid_o), 32'd1);
        chk("dispatch_ra", mul_ra_operand_o, ra);
        chk("dispatch_rb", mul_rb_operand_o, rb);
        chk("dispatch_rd", 32'(mul_rd_idx_o), 32'(rd));
        chk("dispatch_op", mul_opcode_o, op);
        chk("dispatch_pc", mul_pc_o, pc);
        chk("dispatch_notready", 32'(issue_ready_o), 32'd0);
        // multiplier emulation: operate on what was actually dispatched
        prod = mul_ra_operand_o * mul_rb_operand_o;
        ha = hz ? rd : 5'($urandom);
        hb = 5'($urandom);
        hzd_ra_idx_i = ha;
        hzd_rb_idx_i = hb;
        #1;
        chk("hzd_pending", 32'(hzd_stall_o), 32'((rd != 5'd0) && (ha == rd || hb == rd)));
        tick();
        chk("wait_no_strobe", 32'(mul_valid_o), 32'd0);
        chk("wait_busy", 32'(busy_o), 32'd1);
        if (tmo) begin
            repeat (TMO - 1) tick();
            chk("tmo_last_busy", 32'(busy_o), 32'd1);
            chk("tmo_last_err", 32'(err_o), 32'(exp_err));
            tick();
            exp_err = 1'b1;
            chk("tmo_err", 32'(err_o), 32'd1);
            chk("tmo_idle", 32'(issue_ready_o), 32'd1);
            chk("tmo_no_wr", 32'(rf_wr_en_o), 32'd0);
            return;
        end
        repeat (w) tick();
        mul_writeback_valid_i = 1'b1;
        mul_writeback_value_i = prod;
        tick();
        mul_writeback_valid_i = 1'b0;
        mul_writeback_value_i = $urandom;
        if (rd == 5'd0) begin
            chk("x0_no_wr", 32'(rf_wr_en_o), 32'd0);
            chk("x0_idle", 32'(issue_ready_o), 32'd1);
        end else begin
            for (int i = 0; i <= bp; i++) begin
                rf_wr_ready_i = (i == bp);
                chk("wr_en", 32'(rf_wr_en_o), 32'd1);
                chk("wr_idx", 32'(rf_wr_idx_o), 32'(rd));
                chk("wr_data", rf_wr_data_o, model);
                chk("wr_notready", 32'(issue_ready_o), 32'd0);
                tick();
            end
            rf_wr_ready_i = 1'b1;
            chk("post_wr_ready", 32'(issue_ready_o), 32'd1);
            chk("post_wr_en", 32'(rf_wr_en_o), 32'd0);
        end
        hzd_ra_idx_i = rd;
        hzd_rb_idx_i = rd;
        #1;
        chk("hzd_idle", 32'(hzd_stall_o), 32'd0);
        chk("txn_err", 32'(err_o), 32'(exp_err));
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        repeat (2) tick();
        rst_ni  = 1'b1;
        exp_err = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0;
        issue_valid_i = 1'b0; issue_opcode_i = '0; issue_pc_i = '0; issue_rd_idx_i = '0;
        issue_ra_operand_i = '0; issue_rb_operand_i = '0;
        hzd_ra_idx_i = '0; hzd_rb_idx_i = '0;
        mul_writeback_valid_i = 1'b0; mul_writeback_value_i = '0;
        rf_wr_ready_i = 1'b1;
        exp_err = 1'b0;
        repeat (2) tick();
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_mul_valid", 32'(mul_valid_o), 32'd0);
        chk("rst_wr_en", 32'(rf_wr_en_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_hzd", 32'(hzd_stall_o), 32'd0);
        rst_ni = 1'b1;
        tick();
        chk("out_of_rst_ready", 32'(issue_ready_o), 32'd1);

        // basic: 0x12345 * 0x100, writeback 5 cycles after dispatch
        do_txn(32'h00012345, 32'h00000100, 5'd5, 4, 0, 1'b0);
        // backpressure: 3 cycles not ready
        do_txn($urandom, $urandom, 5'd12, 4, 3, 1'b0);
        // hazard on rd=7, and none for rd=0 even when index matches
        do_txn($urandom, $urandom, 5'd7, 4, 0, 1'b1);
        do_txn($urandom, $urandom, 5'd0, 4, 0, 1'b1);
        // writeback in the timeout cycle wins; earliest writeback too
        do_txn($urandom, $urandom, 5'd3, TMO - 1, 1, 1'b0);
        do_txn($urandom, $urandom, 5'd31, 0, 0, 1'b0);

        for (int n = 0; n < 30; n++)
            do_txn($urandom, $urandom, 5'($urandom_range(0, 31)),
                   $urandom_range(0, TMO - 1), $urandom_range(0, 3), 1'($urandom_range(0, 1)));

        // spurious writeback while idle
        mul_writeback_valid_i = 1'b1;
        mul_writeback_value_i = 32'hdeadbeef;
        tick();
        mul_writeback_valid_i = 1'b0;
        exp_err = 1'b1;
        chk("spur_err", 32'(err_o), 32'd1);
        chk("spur_no_wr", 32'(rf_wr_en_o), 32'd0);
        tick();
        chk("spur_no_wr2", 32'(rf_wr_en_o), 32'd0);

        // reset while waiting for the multiplier
        issue_valid_i = 1'b1; issue_rd_idx_i = 5'd9;
        issue_ra_operand_i = 32'h11111111; issue_rb_operand_i = 32'h3;
        tick();
        issue_valid_i = 1'b0;
        tick();
        tick();
        hzd_ra_idx_i = 5'd9;
        rst_ni = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy_o), 32'd0);
        chk("midrst_err", 32'(err_o), 32'd0);
        chk("midrst_mul_valid", 32'(mul_valid_o), 32'd0);
        chk("midrst_rd", 32'(mul_rd_idx_o), 32'd0);
        chk("midrst_ra", mul_ra_operand_o, 32'd0);
        chk("midrst_wr_en", 32'(rf_wr_en_o), 32'd0);
        chk("midrst_wr_data", rf_wr_data_o, 32'd0);
        chk("midrst_hzd", 32'(hzd_stall_o), 32'd0);
        repeat (2) tick();
        rst_ni = 1'b1;
        exp_err = 1'b0;
        tick();
        chk("postrst_ready", 32'(issue_ready_o), 32'd1);
        mul_writeback_valid_i = 1'b1;
        mul_writeback_value_i = 32'h33333333;
        tick();
        mul_writeback_valid_i = 1'b0;
        exp_err = 1'b1;
        chk("stray_err", 32'(err_o), 32'd1);
        chk("stray_no_wr", 32'(rf_wr_en_o), 32'd0);
        chk("stray_no_dispatch", 32'(mul_valid_o), 32'd0);
        tick();
        chk("stray_no_wr2", 32'(rf_wr_en_o), 32'd0);

        // timeout, then normal operation resumes with err held
        do_reset();
        chk("clr_err", 32'(err_o), 32'd0);
        do_txn($urandom, $urandom, 5'd20, TMO, 0, 1'b0);
        do_txn($urandom, $urandom, 5'd21, 2, 1, 1'b0);

        tick();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/biriscv_mul_issue_ctrl.md
BIRISCV_MUL_ISSUE_CTRL -- requirements
Module: biriscv_mul_issue_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, max cycles waiting for multiplier writeback after dispatch.
REQ-002 SHALL have ports:
- clk_i  in  1  sole clock, rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- issue_valid_i  in  1  decode offers a MUL instruction.
- issue_ready_o  out  1  controller can accept.
- issue_opcode_i / issue_pc_i  in  32/32  instruction word, PC.
- issue_rd_idx_i  in  5  destination register.
- issue_ra_operand_i / issue_rb_operand_i  in  32/32  source operand values.
- hzd_ra_idx_i / hzd_rb_idx_i  in  5/5  source indices of the instruction currently in decode.
- hzd_stall_o  out  1  RAW hazard against the pending MUL destination.
- mul_valid_o  out  1  one-cycle dispatch strobe to the multiplier.
- mul_opcode_o / mul_pc_o / mul_ra_operand_o / mul_rb_operand_o  out  32 each  latched instruction fields.
- mul_rd_idx_o  out  5  latched destination.
- mul_writeback_valid_i  in  1  multiplier result strobe.
- mul_writeback_value_i  in  32  multiplier result.
- rf_wr_en_o  out  1  register-file write request.
- rf_wr_idx_o / rf_wr_data_o  out  5/32  write index and data.
- rf_wr_ready_i  in  1  register file accepts the write this cycle.
- busy_o  out  1  state != IDLE.
- err_o  out  1  sticky: timeout or spurious writeback.

Function
REQ-003 SHALL implement FSM states IDLE, DISPATCH, WAIT, WRITE.
REQ-004 issue_ready_o SHALL be 1 only in IDLE; acceptance = issue_valid_i & issue_ready_o.
REQ-005 On acceptance: latch all issue_* fields into mul_* registers; go to DISPATCH.
REQ-006 In DISPATCH: mul_valid_o = 1 for exactly that cycle; load the wait counter with 0; go to WAIT.
REQ-007 In WAIT: the counter increments each cycle. If mul_writeback_valid_i = 1, capture mul_writeback_value_i into rf_wr_data_o; go to WRITE if rd != 0, else go to IDLE.
REQ-008 In WAIT, when the counter reaches TIMEOUT_CYCLES-1 with no writeback: set err_o, discard the instruction without writing, go to IDLE.
REQ-009 In WRITE: rf_wr_en_o = 1 with rf_wr_idx_o = latched rd, stable until rf_wr_ready_i = 1; on that cycle go to IDLE.
REQ-010 rf_wr_en_o SHALL be 0 in every state other than WRITE; a write to x0 is never issued.
REQ-011 mul_writeback_valid_i = 1 in IDLE, DISPATCH or WRITE SHALL be ignored for data and SHALL set err_o.
REQ-012 Pending = state in {DISPATCH, WAIT, WRITE}.
REQ-013 hzd_stall_o SHALL be combinational and asserted when all of the following hold:
- Pending.
- Latched rd != 0.
- hzd_ra_idx_i == rd or hzd_rb_idx_i == rd.
REQ-014 Accepted-to-write latency with the 4-stage multiplier and rf_wr_ready_i = 1:
- Accept at cycle T.
- mul_valid_o at T+1.
- Writeback at T+6.
- rf_wr_en_o at T+7.
- Next accept possible at T+8.
REQ-015 At most one instruction SHALL be outstanding; no new dispatch until return to IDLE.
REQ-016 err_o SHALL be cleared only by reset.
REQ-017 Writeback and timeout in the same WAIT cycle: the writeback wins and err_o is not set.

Reset
REQ-018 rst_ni low SHALL asynchronously force:
- State IDLE.
- All outputs 0 except issue_ready_o.
- issue_ready_o = 1 once out of reset.
- Counter 0, err_o 0.
REQ-019 Reset mid-operation SHALL abandon the pending instruction: no rf write, no further mul_valid_o.

Verification
REQ-020 Basic: accept ra=0x00012345, rb=0x00000100, rd=5. Required response:
- mul_valid_o pulses at T+1.
- Writeback 0x01234500 at T+6.
- rf_wr_en_o, idx 5, data 0x01234500 at T+7.
REQ-021 Backpressure: rf_wr_ready_i held low 3 cycles in WRITE -> rf_wr_en_o, idx and data held stable for 4 cycles; issue_ready_o = 0 until the cycle after the ack.
REQ-022 Hazard: pending rd=7. Required response:
- hzd_ra_idx_i=7 -> hzd_stall_o = 1.
- Pending rd=0 with hzd_ra_idx_i=0 -> hzd_stall_o = 0.
REQ-023 Timeout: no writeback for 16 cycles after dispatch -> err_o = 1, back to IDLE, no rf write.
REQ-024 Spurious writeback in IDLE -> err_o = 1 and rf_wr_en_o stays 0.
REQ-025 Reset asserted in WAIT -> outputs zero immediately; a later stray writeback produces no rf write.
